ula_seq_ctrl: RTL

Sequencing controller wrapped around the 8-bit ULA arithmetic core. It accepts one operation per request over a valid/ready handshake and executes single-cycle ops (ADD, SUB, AND, OR, XOR) directly. MUL runs as a W-cycle shift-add sequence. Each result is returned with its Z/N/C/V flags over an output valid/ready handshake. It sits between the instruction/issue logic and the flags/result consumers, and is the only path through which operations reach the ULA.

---
 rtl/ula_pkg.sv | 21 ++
 rtl/ula_mul_seq.sv | 49 ++++
 rtl/ula_seq_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sequencing controller: opcodes, FSM states
// and the default datapath width.
package ula_pkg;

    localparam int ULA_W = 8;

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_SUB = 5'h01;
    localparam logic [4:0] OP_MUL = 5'h02;
    localparam logic [4:0] OP_AND = 5'h03;
    localparam logic [4:0] OP_OR  = 5'h04;
    localparam logic [4:0] OP_XOR = 5'h05;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/ula_mul_seq.sv
// Shift-add unsigned multiplier. The first partial product is folded in on
// the start edge and one more on each following edge, so the 2W-bit product
// is complete W-1 edges after start and can be captured on edge W.
module ula_mul_seq
    import ula_pkg::*;
#(
    parameter int W = ULA_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] prod
);

    localparam int              CW       = $clog2(W + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(W);

    logic [2*W-1:0] accQ;
    logic [2*W-1:0] mcandQ;
    logic [W-1:0]   mplierQ;
    logic [CW-1:0]  cntQ;

    // Accumulate one partial product per cycle; cntQ counts partials already added.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accQ    <= '0;
            mcandQ  <= '0;
            mplierQ <= '0;
            cntQ    <= '0;
        end else if (start) begin
            accQ    <= b[0] ? {{W{1'b0}}, a} : '0;
            mcandQ  <= {{W{1'b0}}, a} << 1;
            mplierQ <= b >> 1;
            cntQ    <= CW'(1);
        end else if ((cntQ != '0) && (cntQ != CNT_FULL)) begin
            accQ    <= accQ + (mplierQ[0] ? mcandQ : '0);
            mcandQ  <= mcandQ << 1;
            mplierQ <= mplierQ >> 1;
            cntQ    <= cntQ + CW'(1);
        end
    end

    assign done = (cntQ == CNT_FULL);
    assign prod = accQ;

endmodule

// File: rtl/ula_seq_ctrl.sv
// Sequencing controller around the ULA core: valid/ready request intake,
// single-cycle logic/arithmetic ops, W-cycle shift-add MUL, and a registered
// result with Z/N/C/V flags held until the consumer takes it.
module ula_seq_ctrl
    import ula_pkg::*;
#(
    parameter int W = ULA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [4:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r,
    output logic [W-1:0] out_hi,
    output logic         out_z,
    output logic         out_n,
    output logic         out_c,
    output logic         out_v,
    output logic         out_err,
    output logic         busy
);

    localparam int            IW        = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] ITER_LAST = IW'(W - 1);

    state_t         stateQ;
    logic [W-1:0]   aQ, bQ;
    logic [4:0]     opQ;
    logic [IW-1:0]  iterQ;
    logic [W-1:0]   rQ, hiQ;
    logic           zQ, nQ, cQ, vQ, errQ, validQ;

    logic [W-1:0]   bEff;
    logic [W:0]     sum;
    logic [W-1:0]   rD, hiD;
    logic           zD, nD, cD, vD, errD;
    logic           mulStart, mulDone;
    logic [2*W-1:0] prod;

    // The multiplier sees the raw request operands on the accept edge.
    assign mulStart = (stateQ == IDLE) && in_valid && (in_op == OP_MUL);

    ula_mul_seq #(.W(W)) uMul (
        .clk   (clk),
        .rst   (rst),
        .start (mulStart),
        .a     (in_a),
        .b     (in_b),
        .done  (mulDone),
        .prod  (prod)
    );

    // Result and flag selection from the latched operands; illegal opcodes fall to the error case.
    always_comb begin
        bEff = (opQ == OP_SUB) ? ~bQ : bQ;
        sum  = {1'b0, aQ} + {1'b0, bEff} + {{W{1'b0}}, (opQ == OP_SUB)};
        rD   = '0;
        hiD  = '0;
        cD   = 1'b0;
        vD   = 1'b0;
        errD = 1'b0;
        case (opQ)
            OP_ADD, OP_SUB: begin
                rD = sum[W-1:0];
                cD = sum[W];
                vD = ~(aQ[W-1] ^ bEff[W-1]) & (aQ[W-1] ^ sum[W-1]);
            end
            OP_MUL: begin
                rD  = prod[W-1:0];
                hiD = prod[2*W-1:W];
                cD  = |prod[2*W-1:W];
                vD  = |prod[2*W-1:W];
            end
            OP_AND:  rD = aQ & bQ;
            OP_OR:   rD = aQ | bQ;
            OP_XOR:  rD = aQ ^ bQ;
            default: errD = 1'b1;
        endcase
        zD = ~errD & (rD == '0);
        nD = ~errD & rD[W-1];
    end

    // Control FSM with registered results, loaded only on the transition into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
            aQ     <= '0;
            bQ     <= '0;
            opQ    <= '0;
            iterQ  <= '0;
            rQ     <= '0;
            hiQ    <= '0;
            zQ     <= 1'b0;
            nQ     <= 1'b0;
            cQ     <= 1'b0;
            vQ     <= 1'b0;
            errQ   <= 1'b0;
            validQ <= 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (in_valid) begin
                        aQ     <= in_a;
                        bQ     <= in_b;
                        opQ    <= in_op;
                        iterQ  <= '0;
                        stateQ <= (in_op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    rQ     <= rD;
                    hiQ    <= hiD;
                    zQ     <= zD;
                    nQ     <= nD;
                    cQ     <= cD;
                    vQ     <= vD;
                    errQ   <= errD;
                    validQ <= 1'b1;
                    stateQ <= DONE;
                end
                MUL: begin
                    if ((iterQ == ITER_LAST) && mulDone) begin
                        iterQ  <= '0;
                        rQ     <= rD;
                        hiQ    <= hiD;
                        zQ     <= zD;
                        nQ     <= nD;
                        cQ     <= cD;
                        vQ     <= vD;
                        errQ   <= errD;
                        validQ <= 1'b1;
                        stateQ <= DONE;
                    end else begin
                        iterQ <= iterQ + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        validQ <= 1'b0;
                        stateQ <= IDLE;
                    end
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

    assign in_ready  = (stateQ == IDLE);
    assign busy      = (stateQ != IDLE);
    assign out_valid = validQ;
    assign out_r     = rQ;
    assign out_hi    = hiQ;
    assign out_z     = zQ;
    assign out_n     = nQ;
    assign out_c     = cQ;
    assign out_v     = vQ;
    assign out_err   = errQ;

endmodule
